// File: rtl/bin_to_bcd_serial_if.sv
// bin_to_bcd_serial_if: valid/ready bundle carrying words into and BCD results out of the converter
interface bin_to_bcd_serial_if #(parameter int BIN_W = 8, parameter int DIGITS = 3);
  logic in_valid, in_ready, out_valid, out_ready, overflow, busy;
  logic [BIN_W-1:0] bin_in;
  logic [4*DIGITS-1:0] bcd_out;
  modport master (output in_valid, bin_in, out_ready, input in_ready, out_valid, bcd_out, overflow, busy);
  modport slave (input in_valid, bin_in, out_ready, output in_ready, out_valid, bcd_out, overflow, busy);
endinterface

// File: rtl/bin_to_bcd_serial.sv
// bin_to_bcd_serial: one-bit-per-clock double-dabble binary to packed BCD converter
module bin_to_bcd_serial #(
  parameter int BIN_W = 8,
  parameter int DIGITS = 3
) (
  input logic clk,
  input logic rst_n,
  bin_to_bcd_serial_if.slave bus
);
  localparam int CW = $clog2(BIN_W + 1);
  localparam int BW = 4 * DIGITS;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_nx;
  logic [BW-1:0] bcd, adj;
  logic [BIN_W-1:0] bin;
  logic [CW-1:0] cnt;
  logic ovf;
  // per-digit add-3 correction; no carry between digits, so each nibble wraps on its own
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    assign adj[4*g +: 4] = (bcd[4*g +: 4] >= 4'd5) ? bcd[4*g +: 4] + 4'd3 : bcd[4*g +: 4];
  end
  // next-state: accept in IDLE, run BIN_W iterations, wait for the consumer in DONE
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = bus.in_valid ? SHIFT : IDLE;
      SHIFT: state_nx = (cnt == CW'(1)) ? DONE : SHIFT;
      DONE: state_nx = bus.out_ready ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  // state register plus datapath; the bit leaving the top digit is a carry past DIGITS, so it latches overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      bcd <= '0;
      bin <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && bus.in_valid) begin
        bin <= bus.bin_in;
        bcd <= '0;
        ovf <= 1'b0;
        cnt <= CW'(BIN_W);
      end else if (state == SHIFT) begin
        bcd <= {adj[BW-2:0], bin[BIN_W-1]};
        bin <= bin << 1;
        cnt <= cnt - 1'b1;
        ovf <= ovf | adj[BW-1];
      end
    end
  end
  assign bus.in_ready = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy = (state != IDLE);
  assign bus.bcd_out = bcd;
  assign bus.overflow = ovf;
endmodule

// File: tb/tb_bin_to_bcd_serial.sv
// tb_bin_to_bcd_serial: table vectors, hand sequences and exhaustive sweep with a scoreboard queue
module tb_bin_to_bcd_serial;
  typedef struct { logic [7:0] bin; logic [11:0] bcd; logic ovf; int hold; } vec_t;
  typedef struct { logic [11:0] bcd; logic ovf; } exp_t;
  logic clk = 1'b0, rst_n = 1'b0;
  int tests = 0, fails = 0;
  exp_t sb[$];
  vec_t vecs[5];
  logic [7:0] b_bin [2] = '{8'd200, 8'd42};
  logic [7:0] b_bcd [2] = '{8'h00, 8'h42};
  logic b_ovf [2] = '{1'b1, 1'b0};
  bin_to_bcd_serial_if #(.BIN_W(8), .DIGITS(3)) a ();
  bin_to_bcd_serial_if #(.BIN_W(8), .DIGITS(2)) b ();
  bin_to_bcd_serial #(.BIN_W(8), .DIGITS(3)) dut (.clk(clk), .rst_n(rst_n), .bus(a));
  bin_to_bcd_serial #(.BIN_W(8), .DIGITS(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b));
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  function automatic exp_t model(input int v, input int d);
    exp_t e;
    int p = 1;
    e.bcd = '0;
    for (int i = 0; i < d; i++) begin
      e.bcd[4*i +: 4] = 4'((v / p) % 10);
      p *= 10;
    end
    e.ovf = (v >= p);
    return e;
  endfunction
  task automatic send_a(input logic [7:0] v, input exp_t e, input int hold);
    int n = 0;
    exp_t got;
    while (!a.in_ready && n < 40) begin @(negedge clk); n++; end
    check("in_ready_idle", a.in_ready, 1);
    a.bin_in = v;
    a.in_valid = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    a.in_valid = 1'b0;
    a.bin_in = ~v;
    n = 0;
    while (!a.out_valid && n < 40) begin @(negedge clk); n++; end
    check("latency", n, 8);
    for (int i = 0; i < hold; i++) begin
      a.in_valid = i[0];
      a.bin_in = 8'd7;
      @(negedge clk);
      check("hold_valid", a.out_valid, 1);
      check("hold_in_ready", a.in_ready, 0);
      check("hold_bcd", a.bcd_out, e.bcd);
    end
    a.in_valid = 1'b0;
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL scoreboard: got empty queue, expected an entry");
      return;
    end
    got = sb.pop_front();
    check("bcd", a.bcd_out, got.bcd);
    check("ovf", a.overflow, got.ovf);
    check("busy_done", a.busy, 1);
    for (int i = 0; i < 3; i++) begin
      check("digit_range", a.bcd_out[4*i +: 4] <= 4'd9, 1);
      check("xs3", 32'(a.bcd_out[4*i +: 4]) + 3, 32'(got.bcd[4*i +: 4]) + 3);
    end
    a.out_ready = 1'b1;
    @(negedge clk);
    a.out_ready = 1'b0;
    check("out_valid_drop", a.out_valid, 0);
    check("in_ready_back", a.in_ready, 1);
    check("idle_hold", a.bcd_out, got.bcd);
  endtask
  initial begin
    int n;
    int seen;
    exp_t e;
    a.in_valid = 1'b0; a.out_ready = 1'b0; a.bin_in = '0;
    b.in_valid = 1'b0; b.out_ready = 1'b0; b.bin_in = '0;
    vecs[0] = '{8'd255, 12'h255, 1'b0, 0};
    vecs[1] = '{8'd0, 12'h000, 1'b0, 0};
    vecs[2] = '{8'd99, 12'h099, 1'b0, 0};
    vecs[3] = '{8'd100, 12'h100, 1'b0, 0};
    vecs[4] = '{8'd137, 12'h137, 1'b0, 5};
    #1;
    check("rst_in_ready", a.in_ready, 1);
    check("rst_out_valid", a.out_valid, 0);
    check("rst_busy", a.busy, 0);
    check("rst_bcd", a.bcd_out, 0);
    check("rst_ovf", a.overflow, 0);
    check("rst_b_in_ready", b.in_ready, 1);
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    foreach (vecs[i]) begin
      e.bcd = vecs[i].bcd;
      e.ovf = vecs[i].ovf;
      send_a(vecs[i].bin, e, vecs[i].hold);
    end
    for (int k = 0; k < 2; k++) begin
      check("b_in_ready", b.in_ready, 1);
      b.bin_in = b_bin[k];
      b.in_valid = 1'b1;
      @(negedge clk);
      b.in_valid = 1'b0;
      n = 0;
      while (!b.out_valid && n < 40) begin @(negedge clk); n++; end
      check("b_latency", n, 8);
      check("b_bcd", b.bcd_out, b_bcd[k]);
      check("b_ovf", b.overflow, b_ovf[k]);
      b.out_ready = 1'b1;
      @(negedge clk);
      b.out_ready = 1'b0;
    end
    a.bin_in = 8'd255;
    a.in_valid = 1'b1;
    @(negedge clk);
    a.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("busy_shift", a.busy, 1);
    rst_n = 1'b0;
    #1;
    check("abort_in_ready", a.in_ready, 1);
    check("abort_out_valid", a.out_valid, 0);
    check("abort_busy", a.busy, 0);
    check("abort_bcd", a.bcd_out, 0);
    check("abort_ovf", a.overflow, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (a.out_valid) seen++;
    end
    check("abort_no_out", seen, 0);
    check("abort_ready", a.in_ready, 1);
    for (int v = 0; v < 256; v++) send_a(8'(v), model(v, 3), 0);
    check("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
